// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundle of the request, ALU and response signals around alu_arbiter.
//
// Parameters:
//   NREQ  - number of requesters
//   WIDTH - operand / result width
//   IDW   - requester ID width (2**IDW >= NREQ)
//
// Signal groups:
//   req_*  - per-requester valid/ready handshake, packed operands and op bits
//   alu_*  - operand/control outputs to the shared combinational ALU and
//            its result/overflow inputs
//   rsp_*  - single-entry response register with valid/ready handshake
//
// Modports:
//   master - the arbiter: drives req_ready, alu_* controls and rsp_*
//   slave  - the surroundings: requesters, ALU and response consumer
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) ();

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_sub;
    logic [NREQ-1:0]       req_sign;

    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic                  alu_sub;
    logic                  alu_sign;
    logic [WIDTH-1:0]      alu_p;
    logic                  alu_overflow;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_p;
    logic                  rsp_ovf;

    modport master (
        input  req_valid, req_a, req_b, req_sub, req_sign,
        input  alu_p, alu_overflow,
        input  rsp_ready,
        output req_ready,
        output alu_a, alu_b, alu_sub, alu_sign,
        output rsp_valid, rsp_id, rsp_p, rsp_ovf
    );

    modport slave (
        output req_valid, req_a, req_b, req_sub, req_sign,
        output alu_p, alu_overflow,
        output rsp_ready,
        input  req_ready,
        input  alu_a, alu_b, alu_sub, alu_sign,
        input  rsp_valid, rsp_id, rsp_p, rsp_ovf
    );

endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Round-robin arbiter/sequencer sharing one combinational add/subtract ALU
// between NREQ requesters. The granted requester's operands are steered onto
// the ALU; on accept the ALU result and overflow are captured into a
// single-entry response register tagged with the requester index.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (synchronous release expected)
//   bus    - alu_arbiter_if.master: req_*, alu_*, rsp_* signal groups
//
// Build option:
//   ALU_ARB_SAT_EN - when defined, the captured result saturates whenever the
//                    ALU flags overflow (rsp_ovf still shows the raw flag).
//                    When undefined, the result wraps around unmodified.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_arbiter_if.master      bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic             rsp_valid_r;
    logic [IDW-1:0]   rsp_id_r;
    logic [WIDTH-1:0] rsp_p_r;
    logic             rsp_ovf_r;

    logic             grant_found_s;
    logic [IDW-1:0]   grant_idx_s;
    logic [NREQ-1:0]  grant_oh_s;
    logic [IDW-1:0]   sel_idx_s;
    logic [NREQ-1:0]  sel_oh_s;
    logic             can_accept_s;
    logic [NREQ-1:0]  req_ready_s;
    logic             accept_s;
    logic [IDW-1:0]   next_rr_s;
    logic [WIDTH-1:0] alu_a_s;
    logic [WIDTH-1:0] alu_b_s;
    logic             alu_sub_s;
    logic             alu_sign_s;
    logic [WIDTH-1:0] cap_p_s;

    // (base + k) modulo NREQ, for base < NREQ and k < NREQ
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input int unsigned    k);
        int unsigned sum;
        sum = 32'(base) + k;
        if (sum >= 32'(NREQ)) begin
            sum = sum - 32'(NREQ);
        end else begin
            sum = sum;
        end
        return IDW'(sum);
    endfunction

`ifdef ALU_ARB_SAT_EN
    // Clamp an overflowed result to the end of the range it ran off
    function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] p,
                                                    input logic             ovf,
                                                    input logic             sub,
                                                    input logic             sign,
                                                    input logic             a_msb);
        logic [WIDTH-1:0] r;
        if (!ovf) begin
            r = p;
        end else if (sign) begin
            // Signed overflow always lands on the side of A's sign
            r = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else if (sub) begin
            r = {WIDTH{1'b0}};
        end else begin
            r = {WIDTH{1'b1}};
        end
        return r;
    endfunction
`endif

    // Round-robin search: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = rr_ptr_r;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found_s && bus.req_valid[wrap_add(rr_ptr_r, k)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = wrap_add(rr_ptr_r, k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot decodes of the grant and of the operand-mux select
    always_comb begin
        grant_oh_s = {NREQ{1'b0}};
        sel_oh_s   = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            grant_oh_s[i] = grant_found_s && (grant_idx_s == IDW'(i));
            sel_oh_s[i]   = (sel_idx_s == IDW'(i));
        end
    end

    // With no grant the ALU simply sees requester rr_ptr (result unused)
    assign sel_idx_s = grant_found_s ? grant_idx_s : rr_ptr_r;

    assign can_accept_s = ~rsp_valid_r | bus.rsp_ready;

    // rst_n gate keeps every req_ready low while reset is held, even though
    // the response register is empty and would otherwise accept
    assign req_ready_s = grant_oh_s & {NREQ{can_accept_s & rst_n}};
    assign accept_s    = |(bus.req_valid & req_ready_s);
    assign next_rr_s   = wrap_add(grant_idx_s, 32'd1);

    // AND-OR operand mux from the selected requester onto the ALU inputs
    always_comb begin
        alu_a_s    = {WIDTH{1'b0}};
        alu_b_s    = {WIDTH{1'b0}};
        alu_sub_s  = 1'b0;
        alu_sign_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            alu_a_s    = alu_a_s | (bus.req_a[i*WIDTH +: WIDTH] & {WIDTH{sel_oh_s[i]}});
            alu_b_s    = alu_b_s | (bus.req_b[i*WIDTH +: WIDTH] & {WIDTH{sel_oh_s[i]}});
            alu_sub_s  = alu_sub_s  | (bus.req_sub[i]  & sel_oh_s[i]);
            alu_sign_s = alu_sign_s | (bus.req_sign[i] & sel_oh_s[i]);
        end
    end

    // Value written into rsp_p on accept
`ifdef ALU_ARB_SAT_EN
    assign cap_p_s = sat_result(bus.alu_p, bus.alu_overflow, alu_sub_s,
                                alu_sign_s, alu_a_s[WIDTH-1]);
`else
    assign cap_p_s = bus.alu_p;
`endif

    // Response FSM: EMPTY/FULL with the response register and rr pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {IDW{1'b0}};
            rsp_p_r     <= {WIDTH{1'b0}};
            rsp_ovf_r   <= 1'b0;
            rr_ptr_r    <= {IDW{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_r     <= ST_FULL;
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= grant_idx_s;
                        rsp_p_r     <= cap_p_s;
                        rsp_ovf_r   <= bus.alu_overflow;
                        rr_ptr_r    <= next_rr_s;
                    end else begin
                        state_r     <= ST_EMPTY;
                        rsp_valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (accept_s) begin
                        // Drain and reload in the same cycle: stay FULL
                        state_r     <= ST_FULL;
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= grant_idx_s;
                        rsp_p_r     <= cap_p_s;
                        rsp_ovf_r   <= bus.alu_overflow;
                        rr_ptr_r    <= next_rr_s;
                    end else if (bus.rsp_ready) begin
                        // Payload fields keep their last values after drain
                        state_r     <= ST_EMPTY;
                        rsp_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_FULL;
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.alu_a     = alu_a_s;
    assign bus.alu_b     = alu_b_s;
    assign bus.alu_sub   = alu_sub_s;
    assign bus.alu_sign  = alu_sign_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_p     = rsp_p_r;
    assign bus.rsp_ovf   = rsp_ovf_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter (NREQ=4, WIDTH=32). Contains a
// behavioural model of the shared ALU, a vector table for the arithmetic
// corner cases, and hand-written sequences for round-robin order,
// backpressure and asynchronous reset. Honours ALU_ARB_SAT_EN.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] p;
        logic             ovf;
    } rsp_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        sign;
        logic [31:0] p_wrap;
        logic [31:0] p_sat;
        logic        ovf;
    } vec_t;

    logic clk;
    logic rst_n;

    logic [NREQ-1:0]  req_valid;
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];
    logic [NREQ-1:0]  sub_v;
    logic [NREQ-1:0]  sign_v;
    logic             rsp_ready;

    int n_cmp;
    int n_err;

    int   model_rr;
    bit   model_full;
    rsp_t last_exp;
    rsp_t sb_q [$];

    alu_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Requester side drive
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*WIDTH +: WIDTH] = a_arr[i];
            bus.req_b[i*WIDTH +: WIDTH] = b_arr[i];
        end
    end
    assign bus.req_valid = req_valid;
    assign bus.req_sub   = sub_v;
    assign bus.req_sign  = sign_v;
    assign bus.rsp_ready = rsp_ready;

    // Shared combinational ALU model
    logic [WIDTH-1:0] alu_bx;
    logic [WIDTH:0]   alu_sum;
    assign alu_bx  = bus.alu_b ^ {WIDTH{bus.alu_sub}};
    assign alu_sum = {1'b0, bus.alu_a} + {1'b0, alu_bx} + {{WIDTH{1'b0}}, bus.alu_sub};
    assign bus.alu_p = alu_sum[WIDTH-1:0];
    assign bus.alu_overflow = bus.alu_sign
        ? ((bus.alu_a[WIDTH-1] == alu_bx[WIDTH-1]) && (alu_sum[WIDTH-1] != bus.alu_a[WIDTH-1]))
        : (alu_sum[WIDTH] ^ bus.alu_sub);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result computed with wide integer arithmetic
    function automatic rsp_t ref_op(input int id, input logic [31:0] a, input logic [31:0] b,
                                    input logic sub, input logic sign);
        rsp_t        r;
        logic [32:0] uw;
        logic [31:0] p;
        logic        uovf;
        logic        sovf;
        longint      sa;
        longint      sb;
        longint      sr;
        if (sub) begin
            p    = a - b;
            uovf = (a < b);
        end else begin
            uw   = {1'b0, a} + {1'b0, b};
            p    = uw[31:0];
            uovf = uw[32];
        end
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sr   = sub ? (sa - sb) : (sa + sb);
        sovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.ovf = sign ? sovf : uovf;
`ifdef ALU_ARB_SAT_EN
        if (r.ovf) begin
            if (sign) p = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else      p = sub ? 32'h0000_0000 : 32'hFFFF_FFFF;
        end
`endif
        r.p  = p;
        r.id = 2'(id);
        return r;
    endfunction

    // One cycle: check req_ready against the round-robin model, push the
    // expected response on accept, then check the response register after
    // the edge. g returns the index seen on req_ready (-1 if none).
    task automatic tick(output int g);
        logic [NREQ-1:0] exp_ready;
        int   gi;
        bit   acc;
        rsp_t e;
        #1;
        gi = -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (model_rr + k) % NREQ;
            if (gi < 0 && req_valid[j]) gi = j;
        end
        exp_ready = '0;
        if (gi >= 0 && (!model_full || rsp_ready)) exp_ready[gi] = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        g = -1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
        acc = (exp_ready != '0);
        if (acc) begin
            sb_q.push_back(ref_op(gi, a_arr[gi], b_arr[gi], sub_v[gi], sign_v[gi]));
            model_rr   = (gi + 1) % NREQ;
            model_full = 1'b1;
        end else if (rsp_ready) begin
            model_full = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rsp_valid", 32'(bus.rsp_valid), 32'(model_full));
        if (acc) begin
            e        = sb_q.pop_front();
            last_exp = e;
        end
        check("rsp_id",  32'(bus.rsp_id),  32'(last_exp.id));
        check("rsp_p",   bus.rsp_p,        last_exp.p);
        check("rsp_ovf", 32'(bus.rsp_ovf), 32'(last_exp.ovf));
    endtask

    task automatic model_reset();
        model_rr   = 0;
        model_full = 1'b0;
        last_exp   = '0;
        sb_q.delete();
    endtask

    vec_t vecs [10];
    int   order [5];
    int   g;

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();

        vecs[0] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
        vecs[1] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[2] = '{3, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0000, 1'b1};
        vecs[3] = '{0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0};
        vecs[4] = '{2, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[5] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[6] = '{3, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 32'h2345_6789, 1'b0};
        vecs[7] = '{0, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_0002, 1'b0};
        vecs[8] = '{2, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[9] = '{1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        order = '{0, 1, 2, 3, 0};

        // Reset held with every requester valid
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i]  = 32'h0000_1000 * (i + 1) + 32'h10;
            b_arr[i]  = 32'(i + 3);
            sub_v[i]  = i[0];
            sign_v[i] = i[1];
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // All valid, consumer always ready: one accept per cycle in rr order
        for (int k = 0; k < 5; k++) begin
            tick(g);
            check("rr_order", 32'(g), 32'(order[k]));
        end
        req_valid = '0;

        // Arithmetic corner table, one requester valid at a time
        for (int v = 0; v < 10; v++) begin
            req_valid           = '0;
            a_arr[vecs[v].id]   = vecs[v].a;
            b_arr[vecs[v].id]   = vecs[v].b;
            sub_v[vecs[v].id]   = vecs[v].sub;
            sign_v[vecs[v].id]  = vecs[v].sign;
            req_valid[vecs[v].id] = 1'b1;
            tick(g);
            check("tbl_grant", 32'(g), 32'(vecs[v].id));
            check("tbl_id",  32'(bus.rsp_id), 32'(vecs[v].id));
`ifdef ALU_ARB_SAT_EN
            check("tbl_p",   bus.rsp_p, vecs[v].p_sat);
`else
            check("tbl_p",   bus.rsp_p, vecs[v].p_wrap);
`endif
            check("tbl_ovf", 32'(bus.rsp_ovf), 32'(vecs[v].ovf));
        end
        req_valid = '0;
        tick(g);

        // Backpressure: fill from requester 0, then hold with 2 pending
        req_valid[0] = 1'b1;
        tick(g);
        req_valid    = '0;
        req_valid[2] = 1'b1;
        rsp_ready    = 1'b0;
        repeat (5) begin
            tick(g);
            check("bp_no_grant", 32'(g), 32'hFFFF_FFFF);
        end
        rsp_ready = 1'b1;
        tick(g);
        check("bp_release_grant", 32'(g), 32'd2);
        check("bp_release_id", 32'(bus.rsp_id), 32'd2);

        // Asynchronous reset while a response is held under backpressure
        req_valid = '0;
        rsp_ready = 1'b0;
        #2;
        check("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("arst_rsp_p",     bus.rsp_p,           32'd0);
        check("arst_rsp_id",    32'(bus.rsp_id),     32'd0);
        check("arst_rsp_ovf",   32'(bus.rsp_ovf),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // rr pointer was 3 before reset; after release requester 0 wins
        req_valid = '1;
        rsp_ready = 1'b1;
        tick(g);
        check("post_rst_grant", 32'(g), 32'd0);
        req_valid = '0;
        tick(g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational 32-bit add/subtract ALU between NREQ requesters. Each requester presents operands and an op (add/sub, signed/unsigned) with a valid/ready handshake. The block drives the ALU's operand and control inputs and captures the sum and overflow into a single-entry response register tagged with the requester ID. It sits between the instruction-issue clients and the shared ALU instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width; must match the ALU
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_sub  in  NREQ  1 = A-B, 0 = A+B
- req_sign  in  NREQ  1 = signed overflow rule, 0 = unsigned
- alu_a, alu_b  out  WIDTH  operands to ALU
- alu_sub, alu_sign  out  1  control to ALU
- alu_p  in  WIDTH  ALU result (combinational from alu_*)
- alu_overflow  in  1  ALU overflow (combinational)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of requester that produced the response
- rsp_p  out  WIDTH  result
- rsp_ovf  out  1  overflow flag

## Operation
- ALU contract: p = A + (B ^ {WIDTH{sub}}) + sub mod 2^WIDTH. Overflow is the signed rule when sign=1. When sign=0, overflow is the carry-out for add and the borrow for sub.
- State: rr_ptr (IDW bits) and the response register (rsp_valid, rsp_id, rsp_p, rsp_ovf). Two-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = ~rsp_valid | rsp_ready.
- Grant: the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ. The grant is combinational.
- req_ready[i] = grant[i] & can_accept. At most one bit is high.
- alu_* are muxed from the granted requester. With no grant, alu_* are driven from requester rr_ptr. Values outside an accept are don't-care.
- On accept (a req_valid & req_ready pair at the clock edge):
  - capture alu_p, alu_overflow and the grant index into the response register;
  - set rsp_valid;
  - set rr_ptr = (grant index + 1) mod NREQ.
- On rsp_valid & rsp_ready with no accept: clear rsp_valid and go to EMPTY. rsp_p/rsp_id/rsp_ovf hold their last values.
- Simultaneous drain and accept: the register reloads and rsp_valid stays 1, giving full throughput of one op per cycle.
- Requester rules: req_valid and the operands must stay stable until accepted; the arbiter does not buffer. The consumer must not see rsp_* change while rsp_valid=1 and rsp_ready=0.
- Fairness: a continuously valid requester is accepted within NREQ accepts.
- Requesters at index >= NREQ do not exist. rr_ptr never exceeds NREQ-1.

## Timing
- Reset (async assert, sync release): rsp_valid=0, rsp_p=0, rsp_id=0, rsp_ovf=0, rr_ptr=0, FSM=EMPTY. req_ready is 0 for all requesters during reset.
- Latency: accept at edge N gives rsp_valid=1 after edge N, with the result visible in cycle N+1.
- Backpressure: with rsp_valid=1 and rsp_ready=0, req_ready is all zero and the response holds indefinitely.
- Reset asserted mid-operation drops any held response. The requester whose handshake completed before reset loses its result. No partial state survives.
- Combinational paths: req_valid → req_ready, and req_* → alu_* → (register). There is no path from alu_p to req_ready.

## Configuration
- ALU_ARB_SAT_EN defined: the captured result saturates when the overflow flag is 1:
  - unsigned add → all ones;
  - unsigned sub → 0;
  - signed → 0x7FFFFFFF when the A operand sign bit is 0, 0x80000000 when it is 1 (WIDTH-scaled).
  - rsp_ovf still reports the raw overflow.
- Undefined: rsp_p = alu_p unmodified (wrap-around).

## Test plan
- Reset with all req_valid=1: rsp_valid=0 and req_ready=0 until release; first grant goes to requester 0.
- Requester 2, unsigned add 0xFFFFFFFF+0x1: one cycle later rsp_id=2, rsp_p=0x00000000, rsp_ovf=1. With ALU_ARB_SAT_EN, rsp_p=0xFFFFFFFF.
- Signed add 0x7FFFFFFF+0x1 gives rsp_p=0x80000000, ovf=1 (sat: 0x7FFFFFFF). Unsigned sub 5-7 gives 0xFFFFFFFE, ovf=1 (sat: 0x00000000). Signed sub 5-7 gives 0xFFFFFFFE, ovf=0.
- All four req_valid held high, rsp_ready=1: accepts occur every cycle in order 0,1,2,3,0. Each response matches its operands.
- rsp_ready=0 for 5 cycles while FULL: rsp_* stable and req_ready=0. Raise rsp_ready: the pending requester is accepted in the same cycle and the new response appears the next cycle.
- Assert rst_n=0 while rsp_valid=1 and rsp_ready=0: outputs clear immediately, asynchronously. After release, rr_ptr=0.
